alu_seq_unit: RTL and testbench

- Handshaked, registered ALU execution unit. It is the responder side of the operation interface that our ALU benches and the future control unit drive with OP1/OP2/OPRN.
- Accepts one operation per START pulse and returns a registered result with a DONE pulse. Single-cycle ops take 1 cycle; multiply is iterative shift-add over 32 cycles.
- Sits between the control unit/register file and the writeback path of the processor datapath.

---
 rtl/alu_seq_unit.sv | 145 ++++++++++++++
 tb/tb_alu_seq_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Handshaked registered ALU: single-cycle logic/arith/shift ops and a 32-iteration
// shift-add multiplier. One op per accepted START, completion marked by a DONE pulse.
module alu_seq_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  input  logic [OPRN_WIDTH-1:0] OPRN,
  output logic [DATA_WIDTH-1:0] OUT,
  output logic                  ZERO,
  output logic                  DONE,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  localparam logic [OPRN_WIDTH-1:0] OpAdd = OPRN_WIDTH'(6'h20);
  localparam logic [OPRN_WIDTH-1:0] OpSub = OPRN_WIDTH'(6'h22);
  localparam logic [OPRN_WIDTH-1:0] OpMul = OPRN_WIDTH'(6'h2c);
  localparam logic [OPRN_WIDTH-1:0] OpSrl = OPRN_WIDTH'(6'h02);
  localparam logic [OPRN_WIDTH-1:0] OpSll = OPRN_WIDTH'(6'h01);
  localparam logic [OPRN_WIDTH-1:0] OpAnd = OPRN_WIDTH'(6'h24);
  localparam logic [OPRN_WIDTH-1:0] OpOr  = OPRN_WIDTH'(6'h25);
  localparam logic [OPRN_WIDTH-1:0] OpNor = OPRN_WIDTH'(6'h27);
  localparam logic [OPRN_WIDTH-1:0] OpSlt = OPRN_WIDTH'(6'h2a);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  zero_q, zero_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_err;
  logic                  shift_big;
  logic [DATA_WIDTH-1:0] prod_sum;

  // The full OP2 value is the shift amount, so anything past the width flushes to zero.
  assign shift_big = (OP2 >= DATA_WIDTH'(DATA_WIDTH));

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (OPRN)
      OpAdd:   alu_res = OP1 + OP2;
      OpSub:   alu_res = OP1 - OP2;
      OpSrl:   alu_res = shift_big ? '0 : (OP1 >> OP2[CntW-1:0]);
      OpSll:   alu_res = shift_big ? '0 : (OP1 << OP2[CntW-1:0]);
      OpAnd:   alu_res = OP1 & OP2;
      OpOr:    alu_res = OP1 | OP2;
      OpNor:   alu_res = ~(OP1 | OP2);
      OpSlt:   alu_res = {{(DATA_WIDTH-1){1'b0}}, (OP1 < OP2)};
      default: alu_err = 1'b1;
    endcase
  end

  assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    zero_d   = zero_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (START) begin
          if (OPRN == OpMul) begin
            mcand_d  = OP1;
            mplier_d = OP2;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            out_d  = alu_res;
            zero_d = (alu_res == '0);
            err_d  = alu_err;
            done_d = 1'b1;
          end
        end
      end
      StMul: begin
        prod_d   = prod_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Counter saturating at all-ones marks the final (DATA_WIDTH-th) iteration.
        if (cnt_q == '1) begin
          out_d   = prod_sum;
          zero_d  = (prod_sum == '0);
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign OUT  = out_q;
  assign ZERO = zero_q;
  assign DONE = done_q;
  assign BUSY = (state_q == StMul);
  assign ERR  = err_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: hand-computed vectors checked with immediate assertions.
module tb_alu_seq_unit;

  localparam logic [5:0] OpAdd = 6'h20;
  localparam logic [5:0] OpSub = 6'h22;
  localparam logic [5:0] OpMul = 6'h2c;
  localparam logic [5:0] OpSrl = 6'h02;
  localparam logic [5:0] OpSll = 6'h01;
  localparam logic [5:0] OpAnd = 6'h24;
  localparam logic [5:0] OpOr  = 6'h25;
  localparam logic [5:0] OpNor = 6'h27;
  localparam logic [5:0] OpSlt = 6'h2a;
  localparam logic [5:0] OpBad = 6'h3f;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [5:0]  oprn;
  logic [31:0] out;
  logic        zero;
  logic        done;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  alu_seq_unit #(
    .DATA_WIDTH(32),
    .OPRN_WIDTH(6)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .START(start),
    .OP1  (op1),
    .OP2  (op2),
    .OPRN (oprn),
    .OUT  (out),
    .ZERO (zero),
    .DONE (done),
    .BUSY (busy),
    .ERR  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    oprn  = op;
    op1   = a;
    op2   = b;
  endtask

  // Single-cycle op: one edge, then result and DONE must be present.
  task automatic single(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_err);
    drive(op, a, b);
    step();
    chk({tag, "_out"}, out, exp);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp == 32'd0)});
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  // Multiply over 32 edges; optional START injection (with changed operands) at cycle inj.
  task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int inj);
    int dones;
    int idles;
    dones = 0;
    idles = 0;
    drive(OpMul, a, b);
    step();
    start = 1'b0;
    chk({tag, "_busy0"}, {31'b0, busy}, 32'd1);
    chk({tag, "_done0"}, {31'b0, done}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      if (i == inj) drive(OpAdd, 32'd1, 32'd1);
      step();
      start = 1'b0;
      if (done) dones++;
      if (!busy) idles++;
    end
    chk({tag, "_early_done"}, 32'(dones), 32'd0);
    chk({tag, "_early_idle"}, 32'(idles), 32'd0);
    step();
    chk({tag, "_out"}, out, exp);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp == 32'd0)});
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    step();
    chk({tag, "_done_after"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int dones;
    rst   = 1'b1;
    start = 1'b0;
    op1   = '0;
    op2   = '0;
    oprn  = '0;
    step();
    step();
    chk("rst_out", out, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_out", out, 32'd0);
    chk("idle_done", {31'b0, done}, 32'd0);

    // Back-to-back single-cycle ops, START held high across edges.
    single("add", OpAdd, 32'd3, 32'd4, 32'd7, 1'b0);
    single("sub", OpSub, 32'd20, 32'd15, 32'd5, 1'b0);
    single("nor", OpNor, 32'd3, 32'd6, 32'hFFFF_FFF8, 1'b0);
    single("slt", OpSlt, 32'd5, 32'd9, 32'd1, 1'b0);
    single("srl", OpSrl, 32'd8, 32'd2, 32'd2, 1'b0);
    single("sll", OpSll, 32'd4, 32'd4, 32'd64, 1'b0);
    single("and", OpAnd, 32'd5, 32'd10, 32'd0, 1'b0);
    single("or", OpOr, 32'd5, 32'd10, 32'd15, 1'b0);
    single("slt_ge", OpSlt, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    single("add_wrap", OpAdd, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
    single("sub_wrap", OpSub, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    single("srl_31", OpSrl, 32'h8000_0000, 32'd31, 32'd1, 1'b0);
    single("srl_32", OpSrl, 32'hFFFF_FFFF, 32'd32, 32'd0, 1'b0);
    start = 1'b0;
    step();
    chk("hold_out", out, 32'd0);
    chk("hold_done", {31'b0, done}, 32'd0);

    mul_run("mul8x4", 32'd8, 32'd4, 32'd32, 0);
    mul_run("mul_big", 32'h0001_0000, 32'h0001_0000, 32'd0, 0);
    mul_run("mul_ign", 32'd7, 32'd6, 32'd42, 10);
    mul_run("mul_trunc", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0);

    // Reset partway through a multiply aborts it silently.
    drive(OpMul, 32'd9, 32'd9);
    step();
    start = 1'b0;
    for (int i = 1; i < 15; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_out", out, 32'd0);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done || busy) dones++;
    end
    chk("abort_quiet", 32'(dones), 32'd0);
    single("post_abort", OpAdd, 32'd2, 32'd2, 32'd4, 1'b0);

    single("sll_40", OpSll, 32'd1, 32'd40, 32'd0, 1'b0);
    single("sll_31", OpSll, 32'd1, 32'd31, 32'h8000_0000, 1'b0);
    single("bad", OpBad, 32'd5, 32'd6, 32'd0, 1'b1);
    start = 1'b0;
    step();
    chk("bad_hold_err", {31'b0, err}, 32'd1);
    chk("bad_hold_done", {31'b0, done}, 32'd0);
    single("clr_err", OpAdd, 32'd1, 32'd1, 32'd2, 1'b0);
    single("bad2", OpBad, 32'd0, 32'd0, 32'd0, 1'b1);
    start = 1'b0;
    mul_run("mul_clr_err", 32'd3, 32'd5, 32'd15, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
